// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller: load-use, branch-operand-in-ID and
// data-memory wait hazards, plus a wait watchdog and hazard statistics.
module hazard_stall_ctrl #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic             useRsD,
  input  logic             useRtD,
  input  logic             branchD,
  input  logic             branchTakenD,
  input  logic             regWriteE,
  input  logic             memReadE,
  input  logic [4:0]       DstRegE,
  input  logic             memReadM,
  input  logic [4:0]       DstRegM,
  input  logic             memReqM,
  input  logic             memReadyM,
  input  logic             clrStats,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             memWait,
  output logic             memTimeout,
  output logic [CNT_W-1:0] loadStallCnt,
  output logic [CNT_W-1:0] branchStallCnt,
  output logic [CNT_W-1:0] memWaitCnt
);

  localparam int unsigned WCW = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {RUN, MWAIT} state_t;

  state_t           state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mw_cnt_q, mw_cnt_d;

  logic lw_stall, br_stall, freeze;

  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src,
                                     input logic use_f);
    return use_f && (dst == src) && (dst != 5'd0);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Hazard detection
  always_comb begin
    lw_stall = memReadE && (reg_match(DstRegE, RsD, useRsD) || reg_match(DstRegE, RtD, useRtD));
    br_stall = branchD &&
               ((regWriteE && (reg_match(DstRegE, RsD, useRsD) || reg_match(DstRegE, RtD, useRtD))) ||
                (memReadM  && (reg_match(DstRegM, RsD, useRsD) || reg_match(DstRegM, RtD, useRtD))));
    freeze   = memReqM && !memReadyM;
  end

  // Pipeline controls; a freeze masks every other hazard until it resolves
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    if (rst) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (freeze) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
    end else if (lw_stall || br_stall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end else if (branchTakenD) begin
      flushD = 1'b1;
    end
  end

  // Memory-wait FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (freeze) state_d = MWAIT;
      MWAIT:   if (memReadyM) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Watchdog and statistics next state; clrStats beats a same-cycle increment
  always_comb begin
    wait_cnt_d = '0;
    timeout_d  = timeout_q;
    load_cnt_d = load_cnt_q;
    br_cnt_d   = br_cnt_q;
    mw_cnt_d   = mw_cnt_q;
    if (freeze) begin
      wait_cnt_d = (wait_cnt_q == WCW'(TIMEOUT)) ? wait_cnt_q : wait_cnt_q + WCW'(1);
    end
    if (clrStats) begin
      timeout_d  = 1'b0;
      load_cnt_d = '0;
      br_cnt_d   = '0;
      mw_cnt_d   = '0;
    end else begin
      if (freeze && (wait_cnt_q == WCW'(TIMEOUT - 1))) timeout_d = 1'b1;
      if (freeze) mw_cnt_d = sat_inc(mw_cnt_q);
      if (lw_stall && !freeze) load_cnt_d = sat_inc(load_cnt_q);
      if (br_stall && !lw_stall && !freeze) br_cnt_d = sat_inc(br_cnt_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      load_cnt_q <= '0;
      br_cnt_q   <= '0;
      mw_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      load_cnt_q <= load_cnt_d;
      br_cnt_q   <= br_cnt_d;
      mw_cnt_q   <= mw_cnt_d;
    end
  end

  assign memWait        = (state_q == MWAIT);
  assign memTimeout     = timeout_q;
  assign loadStallCnt   = load_cnt_q;
  assign branchStallCnt = br_cnt_q;
  assign memWaitCnt     = mw_cnt_q;

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Stall/flush controller for the 5-stage pipeline. It works alongside the EX-stage bypass unit and covers the hazards that bypassing cannot resolve: load-use, branch-operand-in-ID and data-memory wait.
- Drives hold and bubble controls for the IF/ID/EX/MEM pipeline registers.
- Keeps a registered memory-wait FSM, a wait-timeout watchdog and saturating hazard statistics counters.

Parameters:
- CNT_W, 16, width of each statistics counter.
- TIMEOUT, 64, number of consecutive memory-wait cycles after which memTimeout is set.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  asynchronous, active-high reset.
- RsD  input  5  source register rs of the instruction in ID.
- RtD  input  5  source register rt of the instruction in ID.
- useRsD  input  1  ID instruction reads rs.
- useRtD  input  1  ID instruction reads rt.
- branchD  input  1  ID instruction is a branch that compares its operands in ID.
- branchTakenD  input  1  branch or jump in ID redirects the PC.
- regWriteE  input  1  EX instruction writes the register file.
- memReadE  input  1  EX instruction is a load.
- DstRegE  input  5  EX destination register.
- memReadM  input  1  MEM instruction is a load.
- DstRegM  input  5  MEM destination register.
- memReqM  input  1  MEM stage has a data-memory access this cycle.
- memReadyM  input  1  data memory completes the access this cycle.
- clrStats  input  1  synchronous clear of the counters and memTimeout.
- stallF  output  1  hold PC.
- stallD  output  1  hold IF/ID.
- stallE  output  1  hold ID/EX.
- stallM  output  1  hold EX/MEM.
- flushD  output  1  clear IF/ID on the next edge.
- flushE  output  1  insert a bubble into ID/EX on the next edge.
- memWait  output  1  FSM is in MWAIT.
- memTimeout  output  1  sticky watchdog flag.
- loadStallCnt  output  CNT_W  load-use stall cycles.
- branchStallCnt  output  CNT_W  branch-operand stall cycles.
- memWaitCnt  output  CNT_W  memory freeze cycles.

Behaviour:
- Register-match rule: a destination "matches" a source when they are equal, the destination is nonzero, and the corresponding use flag is set.
- lwStall = memReadE and DstRegE matches RsD or RtD.
- brStall = branchD and either:
  - regWriteE and DstRegE matches a source, or
  - memReadM and DstRegM matches a source.
- freeze = memReqM and not memReadyM.
- FSM states are RUN and MWAIT; reset state is RUN.
  - RUN to MWAIT: when freeze is true.
  - MWAIT to RUN: when memReadyM is 1.
  - MWAIT with memReadyM 0: stay in MWAIT.
  - memWait = 1 exactly when the state is MWAIT.
- Outputs are combinational from the current inputs and rst. Priority, highest first:
  - rst high: all stalls 0, flushD = 1, flushE = 1.
  - freeze: stallF, stallD, stallE and stallM = 1; flushD = 0, flushE = 0. The pipeline is fully frozen; a concurrent lwStall, brStall or redirect waits and re-evaluates after the freeze.
  - lwStall or brStall: stallF = 1, stallD = 1, flushE = 1, stallE = 0, stallM = 0, flushD = 0. branchTakenD is ignored because the branch is not yet resolved.
  - branchTakenD alone: flushD = 1; all stalls 0.
  - otherwise: all outputs 0.
- Load-use latency: exactly one bubble. On the next cycle the load is in MEM and bypassing covers it.
- Branch on a load result: branch in ID behind a load in EX gives two stall cycles (first lwStall/brStall, then brStall against MEM).
- Watchdog (waitCnt is internal, width clog2(TIMEOUT)+1, reset 0):
  - increments every cycle freeze is 1 and saturates at TIMEOUT;
  - clears to 0 on any cycle freeze is 0;
  - memTimeout is set on the edge where waitCnt equals TIMEOUT-1 and freeze is still 1.
  - memTimeout stays set until rst or clrStats.
- Counters: all reset to 0; each increments by 1 per cycle its cause selects the stall; each saturates at all-ones and does not wrap.
  - memWaitCnt: freeze cycles.
  - loadStallCnt: lwStall cycles with no freeze.
  - branchStallCnt: brStall cycles with neither lwStall nor freeze.
  - clrStats has priority over a same-cycle increment.
- Reset mid-wait: rst forces RUN, clears waitCnt, memTimeout and the counters immediately; the pending access is abandoned.

Test Plan:
- Load-use: memReadE=1, DstRegE=5, RsD=5, useRsD=1 for one cycle, then the load moves to MEM -> stallF/stallD/flushE=1 for exactly 1 cycle; loadStallCnt=1.
- Zero-register filter: same as the load-use case but DstRegE=0 -> no stall; loadStallCnt stays 0.
- Branch behind load: branchD=1, RtD=7, useRtD=1; cycle 1 memReadE=1 with DstRegE=7, cycle 2 memReadM=1 with DstRegM=7 -> stall 2 cycles; loadStallCnt=1, branchStallCnt=1; then branchTakenD=1 -> flushD=1 for 1 cycle.
- Memory wait: memReqM=1 with memReadyM=0 for 3 cycles, then 1 -> all four stalls high for 3 cycles; memWait=1 for the cycles after entry; memWaitCnt=3; back in RUN.
- Timeout and clear: memReadyM held 0 for 64 cycles -> memTimeout=1 after the 64th freeze edge, memWaitCnt=64; clrStats pulse -> memTimeout=0 and counters 0.
- Async reset mid-MWAIT: assert rst between clock edges -> memWait=0, stalls 0, flushD=flushE=1 immediately, without waiting for a clock edge.
